// File: rtl/unpack_16to12_pkg.sv
// Shared stream definitions for the 16-bit packed pixel channel:
// word types, header layout, frame-tracking states and the FIFO entry format.
package unpack_16to12_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = 4'h4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h5;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_END     = 4'h6;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'h8;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 4'h8;

  // Header word address that carries the image type field.
  localparam int               HDR_ADDR_WIDTH  = 8;
  localparam logic [HDR_ADDR_WIDTH-1:0] IMAGE_TYPE_ADDR = 8'd2;

  // Image type the packer writes into headers of packed frames.
  localparam logic [4:0] PACKED_IMAGE_TYPE = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_FRAME  = 2'd2
  } frame_state_e;

  // Position within the 3-word / 4-pixel packing group.
  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

  typedef struct packed {
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [15:0]            data;
  } fifo_entry_t;

  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
    return |(dt & DTYPE_PIXEL_MASK);
  endfunction

endpackage

// File: rtl/unpack_16to12_fifo.sv
// Elastic FIFO accepting up to two entries and releasing one entry per cycle.
// The caller never writes more than free_cnt + rd entries and only reads
// when not empty; a read frees its slot for writes in the same cycle.
module unpack_fifo
  import unpack_16to12_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic [1:0]                 wr_cnt,
  input  fifo_entry_t                wr_data0,
  input  fifo_entry_t                wr_data1,
  input  logic                       rd,
  output fifo_entry_t                rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + 1'b1;

  // Storage: first entry at the write pointer, second one slot beyond it.
  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count alone, so the array maps onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) r_mem[r_wr_ptr]  <= wr_data0;
    if (wr_cnt == 2'd2) r_mem[w_wr_ptr1] <= wr_data1;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(wr_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(rd);
      r_count  <= r_count + CW'(wr_cnt) - CW'(rd);
    end
  end

  assign rd_data  = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign free_cnt = CW'(DEPTH) - r_count;

endmodule

// File: rtl/unpack_16to12.sv
// Receive-side unpacker: turns 3 packed 16-bit words back into 4 12-bit
// pixels, restores the header image type, and smooths the burstier output
// through an elastic FIFO into a registered output stage.
module unpack_16to12
  import unpack_16to12_pkg::*;
#(
  parameter logic [4:0] UNPACKED_TYPE = 5'h0C,
  parameter int         FIFO_DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]            datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            datao,
  output logic [15:0]            frame_count,
  output logic                   overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  frame_state_e              r_state, w_state_next;
  logic                      r_enable_s;
  logic [HDR_ADDR_WIDTH-1:0] r_hdr_addr;
  logic                      r_packed_hdr;
  logic                      r_unpack_en;
  phase_e                    r_phase, w_phase_next;
  logic [7:0]                r_hold, w_hold_next;
  logic [15:0]               r_frame_count;
  logic                      r_overflow;
  logic                      r_dvo;
  logic [DTYPE_WIDTH-1:0]    r_dtypeo;
  logic [15:0]               r_datao;

  logic                      w_fs, w_fe;
  logic                      w_type_hit;
  logic                      w_unpack_word;
  logic [1:0]                w_req_cnt;
  fifo_entry_t               w_entry0, w_entry1;
  fifo_entry_t               w_rd_data;
  logic                      w_empty, w_rd;
  logic [CW-1:0]             w_free_cnt, w_room;
  logic                      w_drop;
  logic [1:0]                w_wr_cnt;

  assign w_fs = dvi && (dtypei == DTYPE_FRAME_START);
  assign w_fe = dvi && (dtypei == DTYPE_FRAME_END);

  assign w_type_hit = dvi && (r_state == ST_HEADER) && (dtypei == DTYPE_HEADER) &&
                      (r_hdr_addr == IMAGE_TYPE_ADDR) &&
                      (datai[4:0] == PACKED_IMAGE_TYPE) && r_enable_s;

  assign w_unpack_word = dvi && (r_state == ST_FRAME) && r_unpack_en && is_pixel(dtypei);

  // Frame tracking state register.
  always_ff @(posedge clk) begin
    if (!resetb) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Frame tracking next state, driven purely by delimiter word types.
  always_comb begin
    w_state_next = r_state;
    if (dvi) begin
      if (dtypei == DTYPE_HEADER_START)      w_state_next = ST_HEADER;
      else if (dtypei == DTYPE_FRAME_START)  w_state_next = ST_FRAME;
      else if (dtypei == DTYPE_HEADER_END ||
               dtypei == DTYPE_FRAME_END)    w_state_next = ST_IDLE;
    end
  end

  // Enable synchronizer, header address/type tracking and per-frame decision.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_enable_s    <= 1'b0;
      r_hdr_addr    <= '0;
      r_packed_hdr  <= 1'b0;
      r_unpack_en   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_enable_s <= enable;
      if (r_state != ST_HEADER)                      r_hdr_addr <= '0;
      else if (dvi && dtypei == DTYPE_HEADER)        r_hdr_addr <= r_hdr_addr + 1'b1;
      if (w_fs) begin
        r_unpack_en   <= r_enable_s && r_packed_hdr;
        r_packed_hdr  <= 1'b0;
        r_frame_count <= r_frame_count + 16'd1;
      end else if (w_type_hit) begin
        r_packed_hdr  <= 1'b1;
      end
    end
  end

  // Word decode: header rewrite, 3-to-4 unpacking, or plain passthrough.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_req_cnt    = 2'd0;
    w_entry0     = '{dtype: dtypei, data: datai};
    w_entry1     = '{dtype: dtypei, data: 16'h0000};
    w_phase_next = r_phase;
    w_hold_next  = r_hold;
    if (dvi) begin
      w_req_cnt = 2'd1;
      if (w_type_hit)
        w_entry0.data = (datai & 16'hFFE0) | {11'd0, UNPACKED_TYPE};
      if (w_unpack_word) begin
        unique case (r_phase)
          PH0: begin
            w_entry0.data = {4'h0, datai[15:4]};
            w_hold_next   = {r_hold[7:4], datai[3:0]};
            w_phase_next  = PH1;
          end
          PH1: begin
            w_entry0.data = {4'h0, datai[15:8], r_hold[3:0]};
            w_hold_next   = datai[7:0];
            w_phase_next  = PH2;
          end
          PH2: begin
            w_entry0.data = {4'h0, datai[15:12], r_hold[7:0]};
            w_entry1.data = {4'h0, datai[11:0]};
            w_req_cnt     = 2'd2;
            w_phase_next  = PH0;
          end
          default: w_phase_next = PH0;
        endcase
      end
      // A new frame or a frame end discards any partially assembled pixel.
      if (w_fs || w_fe) begin
        w_phase_next = PH0;
        w_hold_next  = 8'h00;
      end
    end
  end

  // Packing phase and held partial-pixel bits.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_phase <= PH0;
      r_hold  <= 8'h00;
    end else begin
      r_phase <= w_phase_next;
      r_hold  <= w_hold_next;
    end
  end

  // A read frees a slot before this cycle's writes claim space.
  assign w_rd     = !w_empty;
  assign w_room   = w_free_cnt + CW'(w_rd);
  assign w_drop   = CW'(w_req_cnt) > w_room;
  assign w_wr_cnt = w_drop ? w_room[1:0] : w_req_cnt;

  unpack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetb   (resetb),
    .wr_cnt   (w_wr_cnt),
    .wr_data0 (w_entry0),
    .wr_data1 (w_entry1),
    .rd       (w_rd),
    .rd_data  (w_rd_data),
    .empty    (w_empty),
    .free_cnt (w_free_cnt)
  );

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetb)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Output register: one FIFO entry per cycle; data holds while idle.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_dvo    <= 1'b0;
      r_dtypeo <= '0;
      r_datao  <= '0;
    end else begin
      r_dvo <= w_rd;
      if (w_rd) begin
        r_dtypeo <= w_rd_data.dtype;
        r_datao  <= w_rd_data.data;
      end
    end
  end

  assign dvo         = r_dvo;
  assign dtypeo      = r_dtypeo;
  assign datao       = r_datao;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;

endmodule
